// File: rtl/clock_reset_sequencer.sv
// Brings up the clock wizard: pulses its reset, qualifies lock, then releases the
// system and ADC domain resets in order, retrying on lock timeout and recovering on lock loss.
module clock_reset_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 12500,
    parameter int LOCK_STABLE  = 64,
    parameter int RELEASE_GAP  = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_locked,
    input  logic       i_restart,
    output logic       o_mmcm_reset,
    output logic       o_sys_reset,
    output logic       o_adc_reset,
    output logic       o_ready,
    output logic       o_fail,
    output logic [7:0] o_lock_loss_count,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        RESET_MMCM = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        REL_SYS    = 3'd3,
        REL_ADC    = 3'd4,
        RUN        = 3'd5,
        FAIL       = 3'd6
    } state_t;

    localparam int RETRY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    // Timers count 0..N-1, so each phase compares against its last count.
    localparam logic [CNT_WIDTH-1:0] RESET_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(RELEASE_GAP - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] timer;
    logic [CNT_WIDTH-1:0] timer_nx;
    logic [RETRY_W-1:0]   retries;
    logic [RETRY_W-1:0]   retries_nx;
    logic [7:0]           loss_nx;
    logic                 lock_meta;
    logic                 locked_s;
    logic                 mmcm_reset_nx;
    logic                 sys_reset_nx;
    logic                 adc_reset_nx;
    logic                 ready_nx;
    logic                 fail_nx;

    // i_locked comes from the MMCM with no relation to i_clock.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values,
            // giving a true two-stage shift; blocking here would collapse it to one flop.
            lock_meta <= i_locked;
            locked_s  <= lock_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state             <= RESET_MMCM;
            timer             <= '0;
            retries           <= '0;
            o_lock_loss_count <= '0;
        end else begin
            state             <= state_nx;
            timer             <= timer_nx;
            retries           <= retries_nx;
            o_lock_loss_count <= loss_nx;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nx   = state;
        timer_nx   = timer;
        retries_nx = retries;
        loss_nx    = o_lock_loss_count;

        if (i_restart) begin
            state_nx   = RESET_MMCM;
            timer_nx   = '0;
            retries_nx = '0;
        end else begin
            unique case (state)
                RESET_MMCM: begin
                    if (timer == RESET_LAST) begin
                        state_nx = WAIT_LOCK;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + CNT_WIDTH'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nx = STABLE;
                        timer_nx = '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer_nx   = '0;
                        retries_nx = retries + RETRY_W'(1);
                        state_nx   = (retries_nx == RETRY_LIMIT) ? FAIL : RESET_MMCM;
                    end else begin
                        timer_nx = timer + CNT_WIDTH'(1);
                    end
                end
                STABLE: begin
                    // A single dropout restarts qualification without spending a retry.
                    if (!locked_s) begin
                        state_nx = WAIT_LOCK;
                        timer_nx = '0;
                    end else if (timer == STABLE_LAST) begin
                        state_nx = REL_SYS;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + CNT_WIDTH'(1);
                    end
                end
                REL_SYS, REL_ADC, RUN: begin
                    if (!locked_s) begin
                        state_nx = RESET_MMCM;
                        timer_nx = '0;
                        loss_nx  = (o_lock_loss_count == 8'hFF) ? 8'hFF
                                                                : o_lock_loss_count + 8'd1;
                    end else if (state == REL_SYS) begin
                        if (timer == GAP_LAST) begin
                            state_nx = REL_ADC;
                            timer_nx = '0;
                        end else begin
                            timer_nx = timer + CNT_WIDTH'(1);
                        end
                    end else if (state == REL_ADC) begin
                        state_nx   = RUN;
                        retries_nx = '0;
                    end
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: begin
                    state_nx = RESET_MMCM;
                    timer_nx = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change on
    // the same edge as o_state and never glitch.
    always_comb begin
        mmcm_reset_nx = (state_nx == RESET_MMCM) || (state_nx == FAIL);
        sys_reset_nx  = !(state_nx inside {REL_SYS, REL_ADC, RUN});
        adc_reset_nx  = !(state_nx inside {REL_ADC, RUN});
        ready_nx      = (state_nx == RUN);
        fail_nx       = (state_nx == FAIL);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_mmcm_reset <= 1'b1;
            o_sys_reset  <= 1'b1;
            o_adc_reset  <= 1'b1;
            o_ready      <= 1'b0;
            o_fail       <= 1'b0;
        end else begin
            o_mmcm_reset <= mmcm_reset_nx;
            o_sys_reset  <= sys_reset_nx;
            o_adc_reset  <= adc_reset_nx;
            o_ready      <= ready_nx;
            o_fail       <= fail_nx;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Scoreboard bench: expected state segments (state, length) are queued with the
// stimulus and retired by a monitor each time o_state changes.
module tb_clock_reset_sequencer;

    logic       i_clock;
    logic       i_reset;
    logic       i_locked;
    logic       i_restart;
    logic       o_mmcm_reset;
    logic       o_sys_reset;
    logic       o_adc_reset;
    logic       o_ready;
    logic       o_fail;
    logic [7:0] o_lock_loss_count;
    logic [2:0] o_state;

    clock_reset_sequencer #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .LOCK_STABLE (8),
        .RELEASE_GAP (3),
        .MAX_RETRIES (2),
        .CNT_WIDTH   (16)
    ) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_locked         (i_locked),
        .i_restart        (i_restart),
        .o_mmcm_reset     (o_mmcm_reset),
        .o_sys_reset      (o_sys_reset),
        .o_adc_reset      (o_adc_reset),
        .o_ready          (o_ready),
        .o_fail           (o_fail),
        .o_lock_loss_count(o_lock_loss_count),
        .o_state          (o_state)
    );

    initial i_clock = 1'b0;
    always #4 i_clock = ~i_clock;

    localparam logic [2:0] S_RESET = 3'd0, S_WAIT = 3'd1, S_STABLE = 3'd2,
                           S_RSYS = 3'd3, S_RADC = 3'd4, S_RUN = 3'd5, S_FAIL = 3'd6;

    typedef struct {
        logic [2:0] st;
        int         len;   // 0 = length not checked
    } seg_t;

    seg_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {mmcm, sys, adc, ready, fail} expected while sitting in a state
    function automatic logic [4:0] exp_outs(input logic [2:0] st);
        case (st)
            S_RESET:  return 5'b11100;
            S_WAIT:   return 5'b01100;
            S_STABLE: return 5'b01100;
            S_RSYS:   return 5'b00100;
            S_RADC:   return 5'b00000;
            S_RUN:    return 5'b00010;
            S_FAIL:   return 5'b11101;
            default:  return 5'b11111;
        endcase
    endfunction

    function automatic logic [4:0] outs_now();
        return {o_mmcm_reset, o_sys_reset, o_adc_reset, o_ready, o_fail};
    endfunction

    task automatic push(input logic [2:0] st, input int len);
        seg_t s;
        s.st  = st;
        s.len = len;
        exp_q.push_back(s);
    endtask

    // Segment monitor
    bit         mon_en = 0;
    bit         armed  = 0;
    bit         skip   = 1;
    bit         glitch = 0;
    logic [2:0] cur_st;
    int         cur_len;
    logic [4:0] cur_outs;

    task automatic close_segment();
        seg_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check("seg_state", {29'd0, cur_st}, {29'd0, e.st});
            if (e.len != 0) check("seg_len", cur_len, e.len);
            check("seg_outs", {27'd0, cur_outs}, {27'd0, exp_outs(e.st)});
            check("seg_glitch", {31'd0, glitch}, 32'd0);
        end
    endtask

    always @(negedge i_clock) begin
        if (!mon_en) begin
            armed = 0;
            skip  = 1;
        end else if (!i_reset) begin
            armed = 0;
            skip  = 0;
        end else if (!armed) begin
            armed    = 1;
            cur_st   = o_state;
            cur_len  = 1;
            cur_outs = outs_now();
            glitch   = 0;
        end else if (o_state == cur_st) begin
            cur_len++;
            if (outs_now() != cur_outs) glitch = 1;
        end else begin
            if (!skip) close_segment();
            skip     = 0;
            cur_st   = o_state;
            cur_len  = 1;
            cur_outs = outs_now();
            glitch   = 0;
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int limit, input string tag);
        int n = 0;
        @(negedge i_clock);
        #1;
        while (o_state !== st && n < limit) begin
            @(negedge i_clock);
            #1;
            n++;
        end
        check(tag, {29'd0, o_state}, {29'd0, st});
    endtask

    task automatic pulse_restart(input logic lock_val);
        tick();
        i_restart = 1'b1;
        i_locked  = lock_val;
        tick();
        i_restart = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        i_reset   = 1'b0;
        i_locked  = 1'b0;
        i_restart = 1'b0;
        mon_en    = 1;
        repeat (3) @(posedge i_clock);
        #2;
        check("rst_state", {29'd0, o_state}, 32'd0);
        check("rst_outs", {27'd0, outs_now()}, {27'd0, 5'b11100});
        check("rst_loss", {24'd0, o_lock_loss_count}, 32'd0);

        // 1: nominal bring-up; lock raised 5 cycles after o_mmcm_reset falls
        push(S_RESET, 4); push(S_WAIT, 8); push(S_STABLE, 8); push(S_RSYS, 3); push(S_RADC, 1);
        tick();
        i_reset = 1'b1;
        wait_state(S_WAIT, 50, "t1_wait");
        repeat (5) @(posedge i_clock);
        #1 i_locked = 1'b1;
        wait_state(S_RUN, 100, "t1_run");
        check("t1_ready", {31'd0, o_ready}, 32'd1);
        check("t1_drained", exp_q.size(), 0);

        // 2: lock chatter during STABLE
        push(S_RUN, 0); push(S_RESET, 4); push(S_WAIT, 5); push(S_STABLE, 5);
        push(S_WAIT, 2); push(S_STABLE, 8); push(S_RSYS, 3); push(S_RADC, 1);
        pulse_restart(1'b0);
        wait_state(S_WAIT, 50, "t2_wait");
        repeat (2) @(posedge i_clock);
        #1 i_locked = 1'b1;
        repeat (5) @(posedge i_clock);
        #1 i_locked = 1'b0;
        repeat (2) @(posedge i_clock);
        #1 i_locked = 1'b1;
        wait_state(S_RUN, 100, "t2_run");
        check("t2_fail", {31'd0, o_fail}, 32'd0);
        check("t2_drained", exp_q.size(), 0);

        // 3: lock never arrives -> two timeouts then FAIL
        push(S_RUN, 0); push(S_RESET, 4); push(S_WAIT, 20); push(S_RESET, 4); push(S_WAIT, 20);
        pulse_restart(1'b0);
        wait_state(S_FAIL, 200, "t3_fail_state");
        for (int i = 0; i < 3; i++) begin
            repeat (20) @(negedge i_clock);
            #1;
            check("t3_hold_state", {29'd0, o_state}, {29'd0, S_FAIL});
            check("t3_hold_fail", {31'd0, o_fail}, 32'd1);
            check("t3_hold_mmcm", {31'd0, o_mmcm_reset}, 32'd1);
        end
        check("t3_drained", exp_q.size(), 0);
        check("t3_loss", {24'd0, o_lock_loss_count}, 32'd0);

        // 4: restart from FAIL, then nominal lock
        push(S_FAIL, 0); push(S_RESET, 4); push(S_WAIT, 8); push(S_STABLE, 8); push(S_RSYS, 3); push(S_RADC, 1);
        tick();
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        check("t4_fail_clear", {31'd0, o_fail}, 32'd0);
        check("t4_state", {29'd0, o_state}, {29'd0, S_RESET});
        wait_state(S_WAIT, 50, "t4_wait");
        repeat (5) @(posedge i_clock);
        #1 i_locked = 1'b1;
        wait_state(S_RUN, 100, "t4_run");
        check("t4_ready", {31'd0, o_ready}, 32'd1);
        check("t4_drained", exp_q.size(), 0);

        // 5: single-cycle lock loss in RUN, repeated past saturation
        for (int i = 0; i < 256; i++) begin
            push(S_RUN, 0); push(S_RESET, 4); push(S_WAIT, 1); push(S_STABLE, 8); push(S_RSYS, 3); push(S_RADC, 1);
            tick();
            i_locked = 1'b0;
            lat = 0;
            while (lat < 10) begin
                tick();
                lat++;
                if (lat == 1) i_locked = 1'b1;
                if (!o_ready) break;
            end
            check("t5_loss_latency", {31'd0, (lat <= 3)}, 32'd1);
            check("t5_resets", {30'd0, o_sys_reset, o_adc_reset}, 32'd3);
            wait_state(S_RUN, 100, "t5_run");
            check("t5_loss_count", {24'd0, o_lock_loss_count}, (i < 255) ? i + 1 : 255);
        end
        check("t5_drained", exp_q.size(), 0);

        // 6: asynchronous reset in the middle of REL_SYS
        mon_en = 0;
        tick();
        i_locked = 1'b0;
        tick();
        i_locked = 1'b1;
        wait_state(S_RSYS, 100, "t6_rsys");
        check("t6_pre_sys", {31'd0, o_sys_reset}, 32'd0);
        #1 i_reset = 1'b0;
        #1;
        check("t6_state", {29'd0, o_state}, 32'd0);
        check("t6_outs", {27'd0, outs_now()}, {27'd0, 5'b11100});
        check("t6_loss", {24'd0, o_lock_loss_count}, 32'd0);
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b1;
        repeat (2) @(posedge i_clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_reset_sequencer.md
Name: clock_reset_sequencer

Overview:
Sequences the clock wizard (MMCM) on the free-running board clock. It pulses the MMCM reset, waits for and qualifies lock, then releases the system and ADC domain resets in a fixed order. It detects loss of lock and retries with a bounded budget. It replaces the raw "valid = not locked" derivation with a controlled, observable bring-up.

Parameters:
RESET_CYCLES, 16, cycles o_mmcm_reset is held high per attempt (must be >=1)
LOCK_TIMEOUT, 12500, cycles allowed in WAIT_LOCK before the attempt fails (100 us at 125 MHz)
LOCK_STABLE, 64, consecutive synchronized-lock cycles required before reset release
RELEASE_GAP, 16, cycles between o_sys_reset and o_adc_reset deassertion
MAX_RETRIES, 3, failed lock attempts before entering FAIL
CNT_WIDTH, 16, timer width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, RELEASE_GAP)

Ports:
i_clock  in  1  free-running 125 MHz input clock; all logic runs on it
i_reset  in  1  asynchronous, active-low reset
i_locked  in  1  MMCM locked; asynchronous to i_clock; 2-flop synchronized internally
i_restart  in  1  single-cycle request to restart the sequence from any state
o_mmcm_reset  out  1  active-high reset to the clock wizard
o_sys_reset  out  1  active-high reset for the 100 MHz system domain
o_adc_reset  out  1  active-high reset for the 400 MHz ADC domain
o_ready  out  1  high only in RUN
o_fail  out  1  sticky; high only in FAIL
o_lock_loss_count  out  8  saturating count of lock losses after qualification
o_state  out  3  current state encoding, for debug

Behaviour:
- Reset state (i_reset low, asynchronous): state RESET_MMCM; timer, retries, and o_lock_loss_count cleared; synchronizer flops cleared; o_mmcm_reset, o_sys_reset, o_adc_reset = 1; o_ready = o_fail = 0.
- All outputs are registered. locked_s is i_locked delayed by 2 flops.
- Encodings: RESET_MMCM=0, WAIT_LOCK=1, STABLE=2, REL_SYS=3, REL_ADC=4, RUN=5, FAIL=6.
- RESET_MMCM: o_mmcm_reset=1, both domain resets=1. After RESET_CYCLES cycles in the state, go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK: o_mmcm_reset=0. If locked_s=1, go to STABLE with the timer cleared.
  - Else, when the timer reaches LOCK_TIMEOUT-1, retries++.
  - If retries then equals MAX_RETRIES, go to FAIL; otherwise go to RESET_MMCM.
- STABLE: count consecutive cycles with locked_s=1. On the LOCK_STABLE-th cycle, go to REL_SYS. If locked_s=0, return to WAIT_LOCK with the timer cleared; the retry count is unchanged.
- REL_SYS: o_sys_reset=0 from the first cycle in the state. After RELEASE_GAP cycles, go to REL_ADC.
- REL_ADC: o_adc_reset=0; next cycle go to RUN. Retries are cleared on RUN entry.
- RUN: o_ready=1, all resets=0.
- Lock loss: locked_s=0 in REL_SYS, REL_ADC or RUN causes the following in the next cycle:
  - o_sys_reset = o_adc_reset = 1 and o_ready = 0;
  - o_lock_loss_count increments, saturating at 255;
  - state goes to RESET_MMCM.
- FAIL: o_mmcm_reset=1, domain resets=1, o_fail=1. Only i_restart or i_reset leaves FAIL.
- i_restart: honoured in any state and has priority over all other transitions. Next cycle: state RESET_MMCM, timer and retries cleared, o_fail=0, domain resets=1. o_lock_loss_count is not cleared.
- Domain resets are generated in the i_clock domain. Each consuming domain must synchronize deassertion locally; that logic is not part of this block.
- No output glitches: every output is a flop.

Test Plan:
Use RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, RELEASE_GAP=3, MAX_RETRIES=2.
1. Nominal: release i_reset; raise i_locked 5 cycles after o_mmcm_reset falls -> o_mmcm_reset high exactly 4 cycles; o_sys_reset falls 8 cycles after locked_s rises; o_adc_reset falls 3 cycles later; o_ready=1 the next cycle; o_state=5.
2. Lock chatter: i_locked high for 5 cycles, low for 2, then high permanently -> STABLE aborts to WAIT_LOCK; o_sys_reset falls only after 8 uninterrupted locked_s cycles; o_fail=0.
3. Timeout/fail: i_locked held 0 -> two 4-cycle o_mmcm_reset pulses, each followed by 20 cycles of WAIT_LOCK; then FAIL with o_fail=1, o_mmcm_reset=1, o_state=6, held indefinitely.
4. Restart from FAIL: pulse i_restart in FAIL, then raise i_locked -> o_fail clears next cycle; the nominal sequence completes to o_ready=1.
5. Lock loss in RUN: drop i_locked for 1 cycle -> o_ready=0 and both resets=1 within 3 cycles of the i_locked fall; o_lock_loss_count=1; the full sequence reruns to RUN. Repeat 256 times -> the count stays at 255.
6. Async reset mid-REL_SYS: assert i_reset low asynchronously -> all outputs reach their reset values immediately, without waiting for an i_clock edge; o_lock_loss_count=0.
